// File: rtl/cv32e40x_rvfi_retire_sched.sv
// cv32e40x_rvfi_retire_sched
//
// Turns WB-stage retirements into ordered RVFI trace records for a tracer or
// formal sink.
//  - Each retirement receives the next value of a 64-bit order counter; the
//    first retirement after reset has order 1.
//  - Interrupt and debug-entry events are captured and attached to the next
//    retired instruction.
//  - Records are queued in a DEPTH-entry FIFO.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   wb_retire_i       instruction retires this cycle
//   wb_pc_i           PC of the retiring instruction
//   wb_trap_i         rvfi_trap of the retiring instruction
//   intr_taken_i      interrupt/NMI taken pulse
//   intr_pc_i         handler address, qualified by intr_taken_i
//   dbg_taken_i       debug-entry pulse
//   dbg_cause_i       debug cause, qualified by dbg_taken_i
//   out_ready_i       consumer accepts the head record
//   out_valid_o       head record valid
//   out_order_o       head order
//   out_pc_o          head PC
//   out_trap_o        head trap
//   out_intr_o        head rvfi_intr_t {valid, order[63:0], pc_wdata[31:0]}
//   out_dbg_o         head debug cause (0 = none)
//   pend_o            an event is waiting for a retirement (registered)
//   ovfl_o            sticky record-drop flag
//   dbg_state_o       event FSM state (0 = RUN, 1 = PEND)
//
// Handshake: a record transfers on any rising edge where out_valid_o and
// out_ready_i are both high. out_valid_o depends only on registered state.
// While valid is high and ready is low, the head record is held stable.
//
// Optional feature: CV32E40X_RVFI_SCHED_OVFL_EN compiles in overflow
// detection, the sticky ovfl_o flag and a drop assertion. Without it, ovfl_o
// is tied to 0. In both builds a retirement into a full FIFO with no pop is
// discarded, and the order counter still advances.

module cv32e40x_rvfi_retire_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_retire_i,
  input  logic [31:0] wb_pc_i,
  input  logic [11:0] wb_trap_i,
  input  logic        intr_taken_i,
  input  logic [31:0] intr_pc_i,
  input  logic        dbg_taken_i,
  input  logic [2:0]  dbg_cause_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [63:0] out_order_o,
  output logic [31:0] out_pc_o,
  output logic [11:0] out_trap_o,
  output logic [96:0] out_intr_o,
  output logic [2:0]  out_dbg_o,
  output logic        pend_o,
  output logic        ovfl_o,
  output logic        dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [11:0] trap;
    logic [96:0] intr;
    logic [2:0]  dbg;
  } rec_t;

  typedef enum logic {S_RUN = 1'b0, S_PEND = 1'b1} state_e;

  state_e      r_state, w_state_nxt;
  logic [63:0] r_order;
  logic [63:0] w_order_nxt;

  // Pending event fields. They are all zero whenever nothing is pending, so a
  // record can take them directly without looking at the FSM state.
  logic        r_p_iv,  w_p_iv;
  logic [63:0] r_p_io,  w_p_io;
  logic [31:0] r_p_pc,  w_p_pc;
  logic [2:0]  r_p_dbg, w_p_dbg;

  rec_t        r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        w_empty, w_full, w_push, w_pop;
  rec_t        w_rec, w_head;

  assign w_order_nxt = r_order + 64'd1;

  // Event FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (intr_taken_i || dbg_taken_i) w_state_nxt = S_PEND;
      S_PEND:  if (wb_retire_i && !intr_taken_i && !dbg_taken_i) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Pending-event update. A retirement consumes everything that is pending,
  // and an event arriving in the same cycle is then stored fresh. An
  // interrupt that arrives while an earlier one is still pending keeps the
  // earlier order and only replaces the handler address.
  always_comb begin
    w_p_iv  = r_p_iv;
    w_p_io  = r_p_io;
    w_p_pc  = r_p_pc;
    w_p_dbg = r_p_dbg;
    if (wb_retire_i) begin
      w_p_iv  = 1'b0;
      w_p_io  = '0;
      w_p_pc  = '0;
      w_p_dbg = '0;
    end
    if (intr_taken_i) begin
      if (!w_p_iv) w_p_io = wb_retire_i ? w_order_nxt : r_order;
      w_p_iv = 1'b1;
      w_p_pc = intr_pc_i;
    end
    if (dbg_taken_i) w_p_dbg = dbg_cause_i;
  end

  always_comb begin
    w_rec.order = w_order_nxt;
    w_rec.pc    = wb_pc_i;
    w_rec.trap  = wb_trap_i;
    w_rec.intr  = {r_p_iv, r_p_io, r_p_pc};
    w_rec.dbg   = r_p_dbg;
  end

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && out_ready_i;
  assign w_push  = wb_retire_i && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_order <= '0;
      r_p_iv  <= 1'b0;
      r_p_io  <= '0;
      r_p_pc  <= '0;
      r_p_dbg <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (wb_retire_i) r_order <= w_order_nxt;
      r_p_iv  <= w_p_iv;
      r_p_io  <= w_p_io;
      r_p_pc  <= w_p_pc;
      r_p_dbg <= w_p_dbg;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_rec;
  end

  assign w_head      = r_mem[r_rd[AW-1:0]];
  assign out_valid_o = !w_empty;
  assign out_order_o = out_valid_o ? w_head.order : '0;
  assign out_pc_o    = out_valid_o ? w_head.pc    : '0;
  assign out_trap_o  = out_valid_o ? w_head.trap  : '0;
  assign out_intr_o  = out_valid_o ? w_head.intr  : '0;
  assign out_dbg_o   = out_valid_o ? w_head.dbg   : '0;
  assign pend_o      = (r_state == S_PEND);
  assign dbg_state_o = r_state;

`ifdef CV32E40X_RVFI_SCHED_OVFL_EN
  logic w_drop;
  logic r_ovfl;
  assign w_drop = wb_retire_i && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_ovfl <= 1'b0;
    else if (w_drop) r_ovfl <= 1'b1;
  end
  assign ovfl_o = r_ovfl;

  // A drop is reported as a warning so that tracing can continue.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!w_drop) else $warning("rvfi retire record dropped, fifo full");
    end
  end
`else
  assign ovfl_o = 1'b0;
`endif

endmodule
